// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: FSM encoding, dataIn2 control
// field positions and the register index that redirects a write to the PC.
package writeback_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CAPTURE,
        WR1,
        WAIT1,
        WR2,
        WAIT2,
        CPSR,
        ACK,
        WAIT_LOW
    } state_t;

    localparam int DEST1_LSB = 0;
    localparam int DEST2_LSB = 4;
    localparam int WR2_BIT   = 8;
    localparam int S_BIT     = 9;

    localparam logic [3:0] PC_IDX = 4'd15;

    // States in which the wait counter runs and may raise errTimeout
    function automatic logic is_wait(input state_t s);
        return (s == WAIT1) || (s == WAIT2) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/writeback_toggle_sync.sv
// Plain flop-chain synchronizer for a level/toggle signal from another block.
module toggle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic chain_reg [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (srst) chain_reg[gi] <= 1'b0;
                    else      chain_reg[gi] <= d;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (srst) chain_reg[gi] <= 1'b0;
                    else      chain_reg[gi] <= chain_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/writeback.sv
// Writeback stage: takes one ALU result per ready/trigger handshake and commits
// it to the regbank write port, the PC and the CPSR in a fixed order.
module writeback
    import writeback_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] dataIn3,
    input  logic [DATA_W-1:0] cpsrIn,
    input  logic              wIn,
    input  logic              readyIn,
    output logic              triggerOut,
    output logic [DATA_W-1:0] dataOutW,
    output logic [ADDR_W-1:0] addrOutW,
    output logic              triggerOutW,
    input  logic              ackInW,
    output logic [DATA_W-1:0] pcOut,
    output logic              pcWe,
    output logic [DATA_W-1:0] cpsrOut,
    output logic              cpsrWe,
    output logic              busy,
    output logic [15:0]       retireCount,
    output logic              errTimeout
);

    localparam int               CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    logic ready_s;
    logic ack_s;

    toggle_sync #(.STAGES(SYNC_STAGES)) u_ready_sync (
        .clk  (clk),
        .srst (reset),
        .d    (readyIn),
        .q    (ready_s)
    );

    toggle_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk  (clk),
        .srst (reset),
        .d    (ackInW),
        .q    (ack_s)
    );

    state_t state_reg, state_next;

    logic [DATA_W-1:0] d1_reg, d2_reg, d3_reg, cpsr_in_reg;
    logic [DATA_W-1:0] data_w_reg, pc_reg, cpsr_reg;
    logic [ADDR_W-1:0] addr_w_reg;
    logic              trig_reg, trig_w_reg, pc_we_reg, cpsr_we_reg, err_reg;
    logic [15:0]       retire_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;

    logic [ADDR_W-1:0] dest1, dest2;
    state_t            after1, after2;

    assign dest1  = d2_reg[DEST1_LSB +: ADDR_W];
    assign dest2  = d2_reg[DEST2_LSB +: ADDR_W];
    // Where to go once the first / second destination has been committed
    assign after2 = d2_reg[S_BIT] ? CPSR : ACK;
    assign after1 = d2_reg[WR2_BIT] ? WR2 : after2;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (ready_s) state_next = CAPTURE;
            // Bundled inputs are stable while ready is high, so route on them live
            CAPTURE: begin
                if (wIn)                    state_next = WR1;
                else if (dataIn2[WR2_BIT])  state_next = WR2;
                else if (dataIn2[S_BIT])    state_next = CPSR;
                else                        state_next = ACK;
            end
            WR1:      state_next = (dest1 == PC_IDX) ? after1 : WAIT1;
            WAIT1:    if (ack_s == trig_w_reg) state_next = after1;
            WR2:      state_next = (dest2 == PC_IDX) ? after2 : WAIT2;
            WAIT2:    if (ack_s == trig_w_reg) state_next = after2;
            CPSR:     state_next = ACK;
            ACK:      state_next = WAIT_LOW;
            WAIT_LOW: if (!ready_s) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_reg       <= '0;
            d2_reg       <= '0;
            d3_reg       <= '0;
            cpsr_in_reg  <= '0;
            data_w_reg   <= '0;
            addr_w_reg   <= '0;
            pc_reg       <= '0;
            cpsr_reg     <= '0;
            trig_reg     <= 1'b0;
            trig_w_reg   <= 1'b0;
            pc_we_reg    <= 1'b0;
            cpsr_we_reg  <= 1'b0;
            err_reg      <= 1'b0;
            retire_reg   <= '0;
            wait_cnt_reg <= '0;
        end else begin
            pc_we_reg   <= 1'b0;
            cpsr_we_reg <= 1'b0;
            case (state_reg)
                CAPTURE: begin
                    d1_reg      <= dataIn1;
                    d2_reg      <= dataIn2;
                    d3_reg      <= dataIn3;
                    cpsr_in_reg <= cpsrIn;
                end
                WR1: begin
                    if (dest1 == PC_IDX) begin
                        pc_reg    <= d1_reg;
                        pc_we_reg <= 1'b1;
                    end else begin
                        addr_w_reg <= dest1;
                        data_w_reg <= d1_reg;
                        trig_w_reg <= ~trig_w_reg;
                    end
                end
                WR2: begin
                    if (dest2 == PC_IDX) begin
                        pc_reg    <= d3_reg;
                        pc_we_reg <= 1'b1;
                    end else begin
                        addr_w_reg <= dest2;
                        data_w_reg <= d3_reg;
                        trig_w_reg <= ~trig_w_reg;
                    end
                end
                CPSR: begin
                    cpsr_reg    <= cpsr_in_reg;
                    cpsr_we_reg <= 1'b1;
                end
                ACK: begin
                    trig_reg   <= ~trig_reg;
                    retire_reg <= retire_reg + 16'd1;
                end
                default: ;
            endcase

            // Timeout only flags the stall; the FSM keeps waiting for its partner
            if (state_next != state_reg && is_wait(state_next)) begin
                wait_cnt_reg <= '0;
            end else if (is_wait(state_reg) && wait_cnt_reg != CNT_MAX) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
                if (wait_cnt_reg == CNT_MAX - 1'b1) err_reg <= 1'b1;
            end
        end
    end

    assign triggerOut  = trig_reg;
    assign dataOutW    = data_w_reg;
    assign addrOutW    = addr_w_reg;
    assign triggerOutW = trig_w_reg;
    assign pcOut       = pc_reg;
    assign pcWe        = pc_we_reg;
    assign cpsrOut     = cpsr_reg;
    assign cpsrWe      = cpsr_we_reg;
    assign busy        = (state_reg != IDLE);
    assign retireCount = retire_reg;
    assign errTimeout  = err_reg;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: the bench plays both the ALU (ready/trigger)
// and the regbank (write request/ack) and records every commit it observes.
module tb_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataIn1, dataIn2, dataIn3, cpsrIn;
    logic        wIn, readyIn, ackInW;
    logic        triggerOut, triggerOutW, pcWe, cpsrWe, busy, errTimeout;
    logic [31:0] dataOutW, pcOut, cpsrOut;
    logic [3:0]  addrOutW;
    logic [15:0] retireCount;

    int tests = 0;
    int fails = 0;

    int          nw, npc, ncpsr;
    logic [31:0] wdata [4];
    logic [3:0]  waddr [4];
    logic [31:0] pc_val, cpsr_val;
    logic        t_prev, tw_prev;

    always #5 clk = ~clk;

    writeback dut (
        .clk         (clk),
        .reset       (reset),
        .dataIn1     (dataIn1),
        .dataIn2     (dataIn2),
        .dataIn3     (dataIn3),
        .cpsrIn      (cpsrIn),
        .wIn         (wIn),
        .readyIn     (readyIn),
        .triggerOut  (triggerOut),
        .dataOutW    (dataOutW),
        .addrOutW    (addrOutW),
        .triggerOutW (triggerOutW),
        .ackInW      (ackInW),
        .pcOut       (pcOut),
        .pcWe        (pcWe),
        .cpsrOut     (cpsrOut),
        .cpsrWe      (cpsrWe),
        .busy        (busy),
        .retireCount (retireCount),
        .errTimeout  (errTimeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_triggerOut"},  {31'd0, triggerOut},  32'd0);
        check({pfx, "_triggerOutW"}, {31'd0, triggerOutW}, 32'd0);
        check({pfx, "_dataOutW"},    dataOutW,             32'd0);
        check({pfx, "_addrOutW"},    {28'd0, addrOutW},    32'd0);
        check({pfx, "_pcOut"},       pcOut,                32'd0);
        check({pfx, "_pcWe"},        {31'd0, pcWe},        32'd0);
        check({pfx, "_cpsrWe"},      {31'd0, cpsrWe},      32'd0);
        check({pfx, "_busy"},        {31'd0, busy},        32'd0);
        check({pfx, "_retire"},      {16'd0, retireCount}, 32'd0);
        check({pfx, "_err"},         {31'd0, errTimeout},  32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        readyIn = 1'b0;
        ackInW  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        t_prev  = 1'b0;
        tw_prev = 1'b0;
    endtask

    // Present one result, acknowledge writes like a regbank, stop at triggerOut toggle
    task automatic run_result(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] d3, input logic [31:0] cp, input logic w,
                              input bit hold);
        bit done = 0;
        nw = 0; npc = 0; ncpsr = 0;
        dataIn1 = d1; dataIn2 = d2; dataIn3 = d3; cpsrIn = cp; wIn = w;
        readyIn = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            if (triggerOutW !== tw_prev) begin
                tw_prev = triggerOutW;
                if (nw < 4) begin
                    waddr[nw] = addrOutW;
                    wdata[nw] = dataOutW;
                end
                nw++;
                ackInW = ~ackInW;
            end
            if (pcWe === 1'b1)   begin npc++;   pc_val   = pcOut;   end
            if (cpsrWe === 1'b1) begin ncpsr++; cpsr_val = cpsrOut; end
            if (triggerOut !== t_prev) begin
                t_prev = triggerOut;
                done = 1;
            end
        end
        check({tag, "_consumed"}, {31'd0, done}, 32'd1);
        if (!hold) begin
            readyIn = 1'b0;
            for (int c = 0; c < 20 && busy === 1'b1; c++) begin
                @(posedge clk); #1;
            end
            check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        end
        $display("[TB] %s: writes=%0d pc=%0d cpsr=%0d retire=%0d", tag, nw, npc, ncpsr, retireCount);
    endtask

    initial begin
        int toggles;
        dataIn1 = '0; dataIn2 = '0; dataIn3 = '0; cpsrIn = '0; wIn = 1'b0;
        do_reset();
        check_reset_outputs("reset");

        // 1: plain register write
        run_result("t1", 32'hDEADBEEF, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 0);
        check("t1_nw",     nw,          1);
        check("t1_addr",   {28'd0, waddr[0]}, 32'd3);
        check("t1_data",   wdata[0],    32'hDEADBEEF);
        check("t1_npc",    npc,         0);
        check("t1_retire", {16'd0, retireCount}, 32'd1);

        // 2: dest1 == 15 goes to the PC only
        run_result("t2", 32'h0000_0100, 32'h0000_000F, 32'h0, 32'h0, 1'b1, 0);
        check("t2_npc",    npc,         1);
        check("t2_pc",     pc_val,      32'h100);
        check("t2_nw",     nw,          0);
        check("t2_retire", {16'd0, retireCount}, 32'd2);

        // 3: two writes to the same register, second value last
        run_result("t3", 32'h11, 32'h0000_0155, 32'h22, 32'h0, 1'b1, 0);
        check("t3_nw",    nw,                 2);
        check("t3_addr0", {28'd0, waddr[0]},  32'd5);
        check("t3_data0", wdata[0],           32'h11);
        check("t3_addr1", {28'd0, waddr[1]},  32'd5);
        check("t3_data1", wdata[1],           32'h22);
        check("t3_final", dataOutW,           32'h22);

        // 4: CPSR-only result
        run_result("t4", 32'h0, 32'h0000_0200, 32'h0, 32'h6000_0010, 1'b0, 0);
        check("t4_ncpsr",  ncpsr,       1);
        check("t4_cpsr",   cpsr_val,    32'h6000_0010);
        check("t4_nw",     nw,          0);
        check("t4_retire", {16'd0, retireCount}, 32'd4);

        // 5: ready held high must not be consumed twice
        run_result("t5", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
        toggles = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (triggerOut !== t_prev) begin toggles++; t_prev = triggerOut; end
        end
        check("t5_no_double", toggles, 0);
        check("t5_busy_held", {31'd0, busy}, 32'd1);
        check("t5_retire",    {16'd0, retireCount}, 32'd5);
        readyIn = 1'b0;
        for (int c = 0; c < 20 && busy === 1'b1; c++) begin @(posedge clk); #1; end
        check("t5_released", {31'd0, busy}, 32'd0);
        run_result("t5b", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        check("t5b_retire", {16'd0, retireCount}, 32'd6);

        // 6: regbank never acknowledges
        dataIn1 = 32'h1234_5678; dataIn2 = 32'h2; wIn = 1'b1; readyIn = 1'b1;
        toggles = 0;
        for (int c = 0; c < 20 && toggles == 0; c++) begin
            @(posedge clk); #1;
            if (triggerOutW !== tw_prev) toggles++;
        end
        check("t6_req", toggles, 1);
        check("t6_addr", {28'd0, addrOutW}, 32'd2);
        repeat (250) @(posedge clk);
        #1 check("t6_err_early", {31'd0, errTimeout}, 32'd0);
        for (int c = 0; c < 20 && errTimeout !== 1'b1; c++) begin @(posedge clk); #1; end
        check("t6_err_set", {31'd0, errTimeout}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd1);
        $display("[TB] t6: errTimeout=%0b busy=%0b", errTimeout, busy);
        do_reset();
        check_reset_outputs("t6_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
